// File: rtl/bcd_stream_div3or5_pkg.sv
// Shared types and constants for the streaming BCD divisibility checker.
package bcd_stream_div3or5_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int         MOD     = 15;

    // Reduce an 8-bit intermediate (at most 14*10+15 = 155) to its residue mod 15.
    function automatic logic [3:0] mod15_reduce(input logic [7:0] v);
        logic [7:0] r;
        r = v % 8'(MOD);
        return r[3:0];
    endfunction

endpackage

// File: rtl/bcd_stream_div3or5_mod15_step.sv
// One Horner step of the running remainder: rem_next = (rem*10 + digit) mod 15.
module bcd_stream_div3or5_mod15_step
    import bcd_stream_div3or5_pkg::*;
(
    input  logic [3:0] rem,
    input  logic [3:0] digit,
    output logic [3:0] rem_next
);

    logic [7:0] sum_s;

    // Widen, multiply-accumulate and fold back into 0..14 in one combinational pass.
    always_comb begin
        sum_s    = ({4'd0, rem} * 8'd10) + {4'd0, digit};
        rem_next = mod15_reduce(sum_s);
    end

endmodule

// File: rtl/bcd_stream_div3or5.sv
// Streaming BCD divisibility checker: digits arrive MSD first, one per accepted beat;
// the result (div by 3, by 5, by either) is presented once the final digit is taken.
// The remainder is tracked mod 15, so number length is unbounded apart from the
// overlength error flag.
module bcd_stream_div3or5
    import bcd_stream_div3or5_pkg::*;
#(
    parameter  int MAX_DIGITS = 8,
    localparam int CW         = $clog2(MAX_DIGITS + 1)
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          digit_valid,
    input  logic [3:0]    digit,
    input  logic          digit_last,
    output logic          digit_ready,
    output logic          result_valid,
    input  logic          result_ready,
    output logic          div3,
    output logic          div5,
    output logic          div3or5,
    output logic          err,
    output logic [CW-1:0] digit_cnt
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

    state_e        state_q, state_d;
    logic [3:0]    rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          digit_ready_q, digit_ready_d;
    logic          result_valid_q, result_valid_d;
    logic          div3_q, div3_d;
    logic          div5_q, div5_d;
    logic          div3or5_q, div3or5_d;
    logic          err_out_q, err_out_d;
    logic [CW-1:0] digit_cnt_q, digit_cnt_d;

    logic          accept_s;
    logic          res_accept_s;
    logic          result_ok_s;
    logic [3:0]    rem_step_s;

    bcd_stream_div3or5_mod15_step u_mod15_step (
        .rem      (rem_q),
        .digit    (digit),
        .rem_next (rem_step_s)
    );

    // Next-state logic: digit accumulation, error tracking and result handshake.
    always_comb begin
        accept_s     = digit_valid & digit_ready_q;
        res_accept_s = result_valid_q & result_ready;
        state_d      = state_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept_s) begin
                    rem_d   = rem_step_s;
                    cnt_d   = (cnt_q == MAX_CNT) ? cnt_q : (cnt_q + CW'(1'b1));
                    // Illegal digit or a digit beyond the limit poisons this number.
                    err_d   = err_q | (digit > BCD_MAX) | (cnt_q == MAX_CNT);
                    state_d = digit_last ? DONE : ACCUM;
                end else begin
                    state_d = state_q;
                end
            end
            DONE: begin
                if (res_accept_s) begin
                    state_d = IDLE;
                    rem_d   = 4'd0;
                    cnt_d   = {CW{1'b0}};
                    err_d   = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = 4'd0;
                cnt_d   = {CW{1'b0}};
                err_d   = 1'b0;
            end
        endcase
    end

    // Output next values derived from next state so outputs are registered without extra latency.
    always_comb begin
        result_valid_d = (state_d == DONE);
        digit_ready_d  = (state_d != DONE);
        result_ok_s    = result_valid_d & ~err_d;
        div3_d         = result_ok_s & ((rem_d % 4'd3) == 4'd0);
        div5_d         = result_ok_s & ((rem_d % 4'd5) == 4'd0);
        div3or5_d      = div3_d | div5_d;
        err_out_d      = result_valid_d & err_d;
        digit_cnt_d    = result_valid_d ? cnt_d : {CW{1'b0}};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q          <= 4'd0;
            cnt_q          <= {CW{1'b0}};
            err_q          <= 1'b0;
            digit_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
            div3_q         <= 1'b0;
            div5_q         <= 1'b0;
            div3or5_q      <= 1'b0;
            err_out_q      <= 1'b0;
            digit_cnt_q    <= {CW{1'b0}};
        end else begin
            rem_q          <= rem_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
            digit_ready_q  <= digit_ready_d;
            result_valid_q <= result_valid_d;
            div3_q         <= div3_d;
            div5_q         <= div5_d;
            div3or5_q      <= div3or5_d;
            err_out_q      <= err_out_d;
            digit_cnt_q    <= digit_cnt_d;
        end
    end

    assign digit_ready  = digit_ready_q;
    assign result_valid = result_valid_q;
    assign div3         = div3_q;
    assign div5         = div5_q;
    assign div3or5      = div3or5_q;
    assign err          = err_out_q;
    assign digit_cnt    = digit_cnt_q;

endmodule

// File: tb/tb_bcd_stream_div3or5.sv
// Self-checking bench for bcd_stream_div3or5: directed cases plus an exhaustive
// 0..999 sweep and random long/illegal numbers, checked against an arithmetic model.
module tb_bcd_stream_div3or5;

    localparam int MAXD = 8;
    localparam int CW   = $clog2(MAXD + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          digit_valid = 1'b0;
    logic [3:0]    digit = 4'd0;
    logic          digit_last = 1'b0;
    logic          result_ready = 1'b0;
    logic          digit_ready;
    logic          result_valid;
    logic          div3;
    logic          div5;
    logic          div3or5;
    logic          err;
    logic [CW-1:0] digit_cnt;

    int vectors = 0;
    int miscompares = 0;
    int digs[$];

    always #5 clk = ~clk;

    bcd_stream_div3or5 #(.MAX_DIGITS(MAXD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digit_valid  (digit_valid),
        .digit        (digit),
        .digit_last   (digit_last),
        .digit_ready  (digit_ready),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .div3         (div3),
        .div5         (div5),
        .div3or5      (div3or5),
        .err          (err),
        .digit_cnt    (digit_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rv, input logic dr, input logic e3,
                           input logic e5, input logic ee, input int ec);
        chk({tag, ".result_valid"}, 32'(result_valid), 32'(rv));
        chk({tag, ".digit_ready"},  32'(digit_ready),  32'(dr));
        chk({tag, ".div3"},         32'(div3),         32'(e3));
        chk({tag, ".div5"},         32'(div5),         32'(e5));
        chk({tag, ".div3or5"},      32'(div3or5),      32'(e3 | e5));
        chk({tag, ".err"},          32'(err),          32'(ee));
        chk({tag, ".digit_cnt"},    32'(digit_cnt),    32'(ec));
    endtask

    // Reference: evaluate the decimal number exactly, then apply the divisibility rules.
    task automatic model(output logic e3, output logic e5, output logic ee, output int ec);
        longint v = 0;
        bit     bad = 1'b0;
        foreach (digs[i]) begin
            v = v * 10 + longint'(digs[i]);
            if (digs[i] > 9) bad = 1'b1;
        end
        if (digs.size() > MAXD) bad = 1'b1;
        ee = bad;
        ec = (digs.size() > MAXD) ? MAXD : digs.size();
        e3 = !bad && (v % 3 == 0);
        e5 = !bad && (v % 5 == 0);
    endtask

    // Present one digit starting at a negedge; return at the negedge after it is taken.
    task automatic send_digit(input int d, input bit last);
        int guard = 0;
        digit_valid = 1'b1;
        digit       = 4'(d);
        digit_last  = last;
        while (digit_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_accept", 32'(digit_ready), 32'd1);
        @(negedge clk);
        digit_valid = 1'b0;
        digit_last  = 1'b0;
    endtask

    // Stream the digits in digs with random gaps, then check and retire the result.
    task automatic run_number(input int hold, input int max_gap);
        logic e3, e5, ee;
        int   ec;
        model(e3, e5, ee, ec);
        foreach (digs[i]) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_digit(digs[i], i == digs.size() - 1);
        end
        chk_all("result", 1'b1, 1'b0, e3, e5, ee, ec);
        for (int h = 0; h < hold; h++) begin
            digit_valid = 1'($urandom_range(0, 1));
            digit       = 4'($urandom_range(0, 15));
            digit_last  = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk_all("hold", 1'b1, 1'b0, e3, e5, ee, ec);
        end
        digit_valid  = 1'b0;
        digit_last   = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk_all("retired", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        // Reset state, both while held and after release.
        repeat (2) @(negedge clk);
        chk_all("in_reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("after_reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Directed numbers.
        digs = '{1, 5};        run_number(1, 0);
        digs = '{7};           run_number(1, 0);
        digs = '{1, 2, 3};     run_number(1, 1);
        digs = '{2, 5, 0};     run_number(1, 1);
        digs = '{4, 10, 2};    run_number(1, 0);
        digs = '{9};           run_number(1, 0);
        digs = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
        run_number(5, 0);

        // Reset in the middle of a number discards the partial value.
        send_digit(3, 1'b0);
        send_digit(3, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all("mid_reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        digs = '{5};           run_number(1, 0);

        // Reset while a result is pending.
        digs = '{6};
        send_digit(6, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all("done_reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Exhaustive 1..3-digit sweep with random gaps.
        for (int n = 0; n < 1000; n++) begin
            digs.delete();
            if (n >= 100) digs.push_back(n / 100);
            if (n >= 10)  digs.push_back((n / 10) % 10);
            digs.push_back(n % 10);
            run_number($urandom_range(0, 2), 1);
        end

        // Random long numbers, occasionally with illegal digits or over length.
        for (int k = 0; k < 40; k++) begin
            int len;
            digs.delete();
            len = $urandom_range(1, 11);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 9) == 0) digs.push_back($urandom_range(10, 15));
                else                           digs.push_back($urandom_range(0, 9));
            end
            run_number($urandom_range(0, 3), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
